// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode/funct3/register fields and a signed 12-bit immediate into an RV32 I/S/B word.
// Latency: one cycle from request accept to out_valid; one word per cycle while out_ready stays high.
// Backpressure: in_ready drops while a held word is stalled or while in ERR; the held word stays stable.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready           request handshake; fmt/opcode/funct3/rd/rs1/rs2/imm are the request fields
//   out_valid/out_ready         output handshake; out_instr is the encoded word, out_addr its word address
//   err, err_code, err_count    ERR-state flag, cause (01 imm range, 10 bad fmt), saturating reject count
//   clear_err                   returns the block from ERR to RUN
//   chk_fail                    only with IMM_ROUNDTRIP_CHK_EN: sticky immediate round-trip mismatch
//
// Optional feature macro: IMM_ROUNDTRIP_CHK_EN
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        err_count,
    input  logic              clear_err
`ifdef IMM_ROUNDTRIP_CHK_EN
    ,
    output logic              chk_fail
`endif
);

    // BASE_ADDR is taken modulo 2^ADDR_W by truncation.
    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [1:0]        r_err_code;
    logic [7:0]        r_err_count;

    logic [11:0]       w_m;
    logic [31:0]       w_enc;
    logic              w_imm_ok;
    logic              w_legal;
    logic              w_accept;
    logic              w_xfer;

    assign w_m      = imm[11:0];
    // In range iff bits 31..11 are a pure sign extension of bit 11.
    assign w_imm_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign w_legal  = (fmt != 2'b11) && w_imm_ok;
    assign in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    // B keeps the halfword offset unshifted: m[11] -> bit 31, m[10] -> bit 7.
    always_comb begin
        w_enc = '0;
        case (fmt)
            2'b00:   w_enc = {w_m, rs1, funct3, rd, opcode};
            2'b01:   w_enc = {w_m[11:5], rs2, rs1, funct3, w_m[4:0], opcode};
            2'b10:   w_enc = {w_m[11], w_m[9:4], rs2, rs1, funct3, w_m[3:0], w_m[10], opcode};
            default: w_enc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_accept && !w_legal) w_state_nxt = ST_ERR;
            ST_ERR:  if (clear_err)            w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= LP_BASE;
            r_err_code  <= 2'b00;
            r_err_count <= 8'd0;
        end else begin
            // Address advances on every departing word; natural wrap goes to 0, not to the base.
            if (w_xfer) begin
                r_out_addr <= r_out_addr + ADDR_W'(1);
            end

            if (w_accept && w_legal) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_enc;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && !w_legal) begin
                r_err_code <= (fmt == 2'b11) ? 2'b10 : 2'b01;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else if ((r_state == ST_ERR) && clear_err) begin
                r_err_code <= 2'b00;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = (r_state == ST_ERR);
    assign err_code  = r_err_code;
    assign err_count = r_err_count;

`ifdef IMM_ROUNDTRIP_CHK_EN
    logic [1:0]  r_fmt;
    logic [31:0] r_imm;
    logic        r_chk_fail;
    logic [11:0] w_rt_m;
    logic [31:0] w_rt_imm;

    // Re-extract the immediate from the held word using the layout of the format it was built with.
    always_comb begin
        w_rt_m = '0;
        case (r_fmt)
            2'b00:   w_rt_m = r_out_instr[31:20];
            2'b01:   w_rt_m = {r_out_instr[31:25], r_out_instr[11:7]};
            2'b10:   w_rt_m = {r_out_instr[31], r_out_instr[7], r_out_instr[30:25], r_out_instr[11:8]};
            default: w_rt_m = '0;
        endcase
        w_rt_imm = {{20{w_rt_m[11]}}, w_rt_m};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fmt      <= 2'b00;
            r_imm      <= '0;
            r_chk_fail <= 1'b0;
        end else begin
            if (w_accept && w_legal) begin
                r_fmt <= fmt;
                r_imm <= imm;
            end
            if (r_out_valid && (w_rt_imm != r_imm)) begin
                r_chk_fail <= 1'b1;
            end
        end
    end

    assign chk_fail = r_chk_fail;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder, default build plus a 2-bit address instance based at 3.
// Latency: drives at falling edges, monitor samples 1 time unit later, directed checks 2 units later.
// Backpressure: exercised by holding out_ready low around accepted words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready, clear_err;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, out_valid, err;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    logic        w_in_ready, w_out_valid, w_err;
    logic [31:0] w_out_instr;
    logic [1:0]  w_out_addr;
    logic [1:0]  w_err_code;
    logic [7:0]  w_err_count;

    instr_encoder u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_code(err_code), .err_count(err_count), .clear_err(clear_err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(3)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr),
        .err(w_err), .err_code(w_err_code), .err_count(w_err_count), .clear_err(clear_err)
    );

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          n_illegal = 0;
    int          exp_addr  = 0;
    logic [31:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [1:0] f, input logic [31:0] im);
        return (f != 2'b11) && ($signed(im) >= -2048) && ($signed(im) <= 2047);
    endfunction

    function automatic logic [31:0] encode(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [31:0] im);
        logic [31:0] m;
        logic [31:0] w;
        m = im & 32'hFFF;
        w = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            2'b00:   w = w | (32'(d) << 7) | (m << 20);
            2'b01:   w = w | (32'(s2) << 20) | ((m & 32'd31) << 7) | ((m >> 5) << 25);
            default: w = w | (32'(s2) << 20) | ((m & 32'd15) << 8) | (((m >> 10) & 32'd1) << 7)
                           | (((m >> 4) & 32'd63) << 25) | (((m >> 11) & 32'd1) << 31);
        endcase
        return w;
    endfunction

    // Immediate generator for B with the unshifted halfword offset.
    function automatic logic [31:0] immgen_b(input logic [31:0] w);
        logic [11:0] m;
        m = {w[31], w[7], w[30:25], w[11:8]};
        return {{20{m[11]}}, m};
    endfunction

    // Scoreboard monitor: every output transfer pops one expected word.
    always @(negedge clk) begin
        logic [31:0] e;
        #1;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_word", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("instr", out_instr, e);
                check_eq("addr", {24'd0, out_addr}, exp_addr & 255);
                check_eq("wrap_valid", {31'd0, w_out_valid}, 32'd1);
                check_eq("wrap_instr", w_out_instr, e);
                check_eq("wrap_addr", {30'd0, w_out_addr}, (exp_addr + 3) & 3);
            end
            exp_addr = (exp_addr + 1) & 255;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        int n;
        fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        #2;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 50) begin
            check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else if (is_legal(f, im)) begin
            sb_q.push_back(encode(f, op, f3, d, s1, s2, im));
        end else begin
            n_illegal++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] h_instr;
        logic [7:0]  h_addr;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
        fmt = 2'b00; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_addr", {24'd0, out_addr}, 32'd0);
        check_eq("rst_wrap_addr", {30'd0, w_out_addr}, 32'd3);
        check_eq("rst_err", {29'd0, err, err_code}, 32'd0);
        check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed encodings from the test plan.
        @(negedge clk);
        send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5);
        #2;
        check_eq("i_lat_valid", {31'd0, out_valid}, 32'd1);
        check_eq("i_instr", out_instr, 32'h00500093);
        @(negedge clk);
        send(2'b01, 7'b0100011, 3'b010, 5'd0, 5'd1, 5'd2, -32'sd4);
        #2;
        check_eq("s_instr", out_instr, 32'hFE20AE23);
        check_eq("s_addr", {24'd0, out_addr}, 32'd1);
        @(negedge clk);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, -32'sd2047);
        #2;
        check_eq("b_instr", out_instr, 32'h80000163);
        check_eq("b_roundtrip", immgen_b(out_instr), 32'hFFFFF801);

        // Backpressure: word held stable for three cycles, then released.
        @(negedge clk);
        out_ready = 1'b0;
        send(2'b00, 7'b0000011, 3'b010, 5'd3, 5'd4, 5'd0, 32'd2047);
        #2;
        h_instr = out_instr;
        h_addr  = out_addr;
        check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bp_addr", {24'd0, h_addr}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check_eq("bp_hold_instr", out_instr, h_instr);
            check_eq("bp_hold_addr", {24'd0, out_addr}, {24'd0, h_addr});
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        check_eq("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #2;
        check_eq("bp_addr_inc", {24'd0, out_addr}, 32'd4);
        check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

        // Out-of-range immediate.
        @(negedge clk);
        send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048);
        #2;
        check_eq("range_err", {31'd0, err}, 32'd1);
        check_eq("range_code", {30'd0, err_code}, 32'd1);
        check_eq("range_count", {24'd0, err_count}, 32'd1);
        check_eq("range_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("range_no_out", {31'd0, out_valid}, 32'd0);
        check_eq("range_addr", {24'd0, out_addr}, 32'd4);
        @(negedge clk);
        clear_err = 1'b1;
        #2;
        check_eq("clear_cycle_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        clear_err = 1'b0;
        #2;
        check_eq("clear_err", {31'd0, err}, 32'd0);
        check_eq("clear_code", {30'd0, err_code}, 32'd0);
        check_eq("clear_count", {24'd0, err_count}, 32'd1);
        check_eq("clear_in_ready", {31'd0, in_ready}, 32'd1);

        // Illegal format.
        @(negedge clk);
        send(2'b11, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
        #2;
        check_eq("fmt_code", {30'd0, err_code}, 32'd2);
        check_eq("fmt_count", {24'd0, err_count}, 32'd2);
        do_clear();

        // Same edge: held word leaves while an illegal request is taken.
        out_ready = 1'b0;
        send(2'b00, 7'b0010011, 3'b111, 5'd9, 5'd10, 5'd0, -32'sd2048);
        out_ready = 1'b1;
        send(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
        #2;
        check_eq("same_edge_valid", {31'd0, out_valid}, 32'd0);
        check_eq("same_edge_addr", {24'd0, out_addr}, 32'd5);
        check_eq("same_edge_err", {29'd0, err, err_code}, 32'd5);
        check_eq("same_edge_count", {24'd0, err_count}, 32'd3);
        do_clear();

        // Back-to-back legal stream with random fields.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ri;
            ri = (i == 0) ? 32'd2047 : (i == 1) ? -32'sd2048 : 32'($urandom_range(0, 4095)) - 32'd2048;
            send(2'($urandom_range(0, 2)), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), ri);
        end

        // Saturating reject counter.
        for (int i = 0; n_illegal < 256; i++) begin
            case (i % 3)
                0:       send(2'b11, 7'h13, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
                1:       send(2'b01, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'hFFFF_F7FF);
                default: send(2'b10, 7'h63, 3'd1, 5'd0, 5'd2, 5'd3, 32'h0000_0800 + 32'(i));
            endcase
            if (n_illegal < 256) do_clear();
        end
        #2;
        check_eq("sat_count", {24'd0, err_count}, 32'd255);
        check_eq("sat_wrap_count", {24'd0, w_err_count}, 32'd255);
        do_clear();

        // Reset with a stalled word discards it.
        out_ready = 1'b0;
        send(2'b00, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'd77);
        reset = 1'b1;
        sb_q.delete();
        exp_addr = 0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #2;
        check_eq("rst2_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst2_addr", {24'd0, out_addr}, 32'd0);
        check_eq("rst2_wrap_addr", {30'd0, w_out_addr}, 32'd3);
        check_eq("rst2_count", {24'd0, err_count}, 32'd0);
        check_eq("rst2_err", {31'd0, w_err}, 32'd0);

        // Five streamed words: wrap instance addresses 3,0,1,2,3.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send(2'b01, 7'h23, 3'd2, 5'd0, 5'(i), 5'(i + 7), 32'(i * 100) - 32'd200);
        end
        repeat (3) @(negedge clk);
        #2;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("final_addr", {24'd0, out_addr}, 32'd5);
        check_eq("final_wrap_addr", {30'd0, w_out_addr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
